// File: rtl/timer_bank.sv
// timer_bank: NUM_TIMERS CPU-visible millisecond timers sharing one prescaler, with
// up/down/auto-reload modes, sticky expiry flags, an interrupt and tear-free reads.
module timer_bank #(
  parameter int NUM_TIMERS = 4,
  parameter int WIDTH      = 16,
  parameter int CLK_KHZ    = 24000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [5:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic       tick
);

  localparam int PW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_KHZ - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

  typedef enum logic [2:0] {
    REG_B0     = 3'd0,
    REG_B1     = 3'd1,
    REG_B2     = 3'd2,
    REG_B3     = 3'd3,
    REG_CTRL   = 3'd4,
    REG_STATUS = 3'd5,
    REG_LOAD   = 3'd6,
    REG_RSVD   = 3'd7
  } reg_e;

  logic                  wrEn;
  logic                  rdEn;
  logic [2:0]            timerSel;
  reg_e                  regSel;
  logic [PW-1:0]         presc_q, presc_d;
  logic [7:0]            dout_q, dout_d;
  logic [7:0]            rdData;
  logic [WIDTH-1:0]      countVec [NUM_TIMERS];
  logic [31:0]           snapVec  [NUM_TIMERS];
  logic [4:0]            ctrlVec  [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] expVec;
  logic [NUM_TIMERS-1:0] ieVec;

  assign wrEn     = cs & wr;
  assign rdEn     = cs & rd;
  assign timerSel = addr[5:3];
  assign regSel   = reg_e'(addr[2:0]);

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PRESC_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      dout_q  <= 8'h00;
    end else begin
      presc_q <= presc_d;
      dout_q  <= dout_d;
    end
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : gTimer
    // Only timer 0 comes out of reset running, mimicking the legacy free-running counter.
    localparam logic [4:0] CTRL_RST = (g == 0) ? 5'h01 : 5'h00;

    logic             sel;
    logic             expSet;
    logic [31:0]      reloadWide;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic             exp_q, exp_d;

    assign sel = (timerSel == 3'(g));

    // Tick evaluation uses the pre-write CTRL and reload; a LOAD suppresses the tick.
    always_comb begin
      count_d    = count_q;
      reload_d   = reload_q;
      snap_d     = snap_q;
      ctrl_d     = ctrl_q;
      exp_d      = exp_q;
      expSet     = 1'b0;
      reloadWide = 32'(reload_q);
      if (sel && wrEn && regSel == REG_LOAD) begin
        count_d = reload_q;
      end else if (tick && ctrl_q[0]) begin
        if (!ctrl_q[1]) begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end else begin
            count_d = ctrl_q[3] ? CNT_MAX : '0;
            expSet  = 1'b1;
          end
        end else begin
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else if (count_q == CNT_ONE) begin
            count_d = ctrl_q[2] ? reload_q : '0;
            expSet  = 1'b1;
          end else if (ctrl_q[2]) begin
            count_d = reload_q;
          end
        end
      end
      if (sel && wrEn) begin
        case (regSel)
          REG_B0, REG_B1, REG_B2, REG_B3: begin
            reloadWide[{addr[1:0], 3'b000} +: 8] = din;
            reload_d = reloadWide[WIDTH-1:0];
          end
          REG_CTRL:   ctrl_d = din[4:0];
          REG_STATUS: if (din[0]) exp_d = 1'b0;
          default:    ;
        endcase
      end
      if (sel && rdEn && regSel == REG_B0) begin
        snap_d = count_q;
      end
      if (expSet) begin
        exp_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_q  <= '0;
        reload_q <= '0;
        snap_q   <= '0;
        ctrl_q   <= CTRL_RST;
        exp_q    <= 1'b0;
      end else begin
        count_q  <= count_d;
        reload_q <= reload_d;
        snap_q   <= snap_d;
        ctrl_q   <= ctrl_d;
        exp_q    <= exp_d;
      end
    end

    assign countVec[g] = count_q;
    assign snapVec[g]  = 32'(snap_q);
    assign ctrlVec[g]  = ctrl_q;
    assign expVec[g]   = exp_q;
    assign ieVec[g]    = ctrl_q[4];
  end

  // Snapshot bytes above WIDTH are zero-extended, so they read back as 0.
  always_comb begin
    rdData = 8'h00;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (timerSel == 3'(i)) begin
        case (regSel)
          REG_B0:                 rdData = countVec[i][7:0];
          REG_B1, REG_B2, REG_B3: rdData = snapVec[i][{addr[1:0], 3'b000} +: 8];
          REG_CTRL:               rdData = {3'b000, ctrlVec[i]};
          REG_STATUS:             rdData = {7'b0000000, expVec[i]};
          default:                rdData = 8'h00;
        endcase
      end
    end
  end

  assign dout_d = rdEn ? rdData : dout_q;
  assign dout   = dout_q;
  assign irq    = |(expVec & ieVec);

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed bus sequences against timer_bank, with a per-cycle
// comparison of dout/irq/tick against a behavioural model of the timer rules.
`timescale 1ns/1ps
module tb_timer_bank;

  localparam int     NT   = 4;
  localparam int     W    = 16;
  localparam int     CK   = 4;
  localparam longint CMAX = (64'd1 << W) - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       irq;
  logic       tick;
  logic [7:0] lastRead;

  int assertCount = 0;
  int failCount = 0;

  timer_bank #(.NUM_TIMERS(NT), .WIDTH(W), .CLK_KHZ(CK)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .rd(rd), .wr(wr),
    .addr(addr), .din(din), .dout(dout), .irq(irq), .tick(tick)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, updated once per clock from the bus inputs.
  longint mCount [NT];
  longint mReload[NT];
  longint mSnap  [NT];
  int     mCtrl  [NT];
  bit     mExp   [NT];
  bit     setNow [NT];
  int     mPresc;
  int     mDout;
  int     mT, mR;
  bit     mTk, loadHit;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NT; i++) begin
        mCount[i] = 0; mReload[i] = 0; mSnap[i] = 0;
        mCtrl[i] = (i == 0) ? 1 : 0; mExp[i] = 0;
      end
      mPresc = 0;
      mDout = 0;
    end else begin
      mT  = int'(addr[5:3]);
      mR  = int'(addr[2:0]);
      mTk = (mPresc == CK - 1);
      mPresc = mTk ? 0 : mPresc + 1;
      if (cs && rd) begin
        mDout = 0;
        if (mT < NT) begin
          if (mR == 0) begin
            mDout = int'(mCount[mT] % 256);
            mSnap[mT] = mCount[mT];
          end else if (mR <= 3) mDout = int'((mSnap[mT] >> (8 * mR)) % 256);
          else if (mR == 4) mDout = mCtrl[mT];
          else if (mR == 5) mDout = mExp[mT] ? 1 : 0;
        end
      end
      for (int i = 0; i < NT; i++) begin
        setNow[i] = 0;
        loadHit = cs && wr && (mT == i) && (mR == 6);
        if (!loadHit && mTk && (mCtrl[i] & 1) != 0) begin
          if ((mCtrl[i] & 2) == 0) begin
            if (mCount[i] < CMAX) mCount[i] = mCount[i] + 1;
            else begin
              if ((mCtrl[i] & 8) == 0) mCount[i] = 0;
              setNow[i] = 1;
            end
          end else begin
            if (mCount[i] > 1) mCount[i] = mCount[i] - 1;
            else if (mCount[i] == 1) begin
              mCount[i] = ((mCtrl[i] & 4) != 0) ? mReload[i] : 0;
              setNow[i] = 1;
            end else if ((mCtrl[i] & 4) != 0) mCount[i] = mReload[i];
          end
        end
      end
      if (cs && wr && mT < NT) begin
        if (mR <= 3) begin
          if (8 * mR < W)
            mReload[mT] = (mReload[mT] & ~(longint'(255) << (8 * mR))) | (longint'(din) << (8 * mR));
        end else if (mR == 4) mCtrl[mT] = int'(din) & 31;
        else if (mR == 5) begin
          if (din[0]) mExp[mT] = 0;
        end else if (mR == 6) mCount[mT] = mReload[mT];
      end
      for (int i = 0; i < NT; i++) if (setNow[i]) mExp[i] = 1;
    end
  end

  function automatic bit modelIrq();
    bit r = 0;
    for (int i = 0; i < NT; i++) if (mExp[i] && (mCtrl[i] & 16) != 0) r = 1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    checkOutput("cycle dout", 64'(dout), 64'(mDout));
    checkOutput("cycle irq", 64'(irq), 64'(modelIrq()));
    checkOutput("cycle tick", 64'(tick), 64'(mPresc == CK - 1));
  end

  task automatic applyStimulus(input bit isWrite, input int t, input int r, input logic [7:0] d);
    addr = 6'((t << 3) | r);
    din  = d;
    cs   = 1'b1;
    rd   = !isWrite;
    wr   = isWrite;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    lastRead = dout;
  endtask

  task automatic readCheck(input string name, input int t, input int r, input logic [7:0] exp);
    applyStimulus(1'b0, t, r, 8'h00);
    checkOutput(name, 64'(lastRead), 64'(exp));
  endtask

  task automatic waitTick();
    int n = 0;
    while (!tick && n < 2 * CK) begin
      @(negedge clk);
      n++;
    end
    if (!tick) checkOutput("tick wait timeout", 64'(tick), 64'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset dout", 64'(dout), 64'(0));
    checkOutput("reset irq", 64'(irq), 64'(0));
    checkOutput("reset tick", 64'(tick), 64'(0));
    reset_n = 1'b1;

    // Free-running timer 0 after 40 clocks at 4 clocks per tick.
    repeat (40) @(negedge clk);
    checkOutput("model t0 count", 64'(mCount[0]), 64'(10));
    readCheck("t0 byte0 after 40 clk", 0, 0, 8'h0A);
    readCheck("t0 byte1 snapshot", 0, 1, 8'h00);
    for (int t = 1; t < NT; t++) readCheck("idle timer count", t, 0, 8'h00);
    checkOutput("irq idle", 64'(irq), 64'(0));
    readCheck("t0 ctrl reset", 0, 4, 8'h01);

    // Timer 1: down, auto-reload 3, interrupt enabled; LOAD lands on a tick.
    applyStimulus(1'b1, 1, 0, 8'h03);
    applyStimulus(1'b1, 1, 1, 8'h00);
    applyStimulus(1'b1, 1, 4, 8'h17);
    waitTick();
    applyStimulus(1'b1, 1, 6, 8'h00);
    readCheck("t1 load over tick", 1, 0, 8'h03);
    readCheck("t1 status after load", 1, 5, 8'h00);
    repeat (10) @(negedge clk);
    checkOutput("t1 irq on expiry", 64'(irq), 64'(1));
    readCheck("t1 status expired", 1, 5, 8'h01);
    readCheck("t1 reloaded", 1, 0, 8'h03);
    applyStimulus(1'b1, 1, 5, 8'h01);
    checkOutput("irq after clear", 64'(irq), 64'(0));
    repeat (4) @(negedge clk);
    checkOutput("irq low tick 1", 64'(irq), 64'(0));
    repeat (4) @(negedge clk);
    checkOutput("irq low tick 2", 64'(irq), 64'(0));
    checkOutput("tick before clear collision", 64'(tick), 64'(1));
    applyStimulus(1'b1, 1, 5, 8'h01);
    readCheck("t1 set beats clear", 1, 5, 8'h01);

    // Timer 2: up from 0xFFFE, first wrapping then saturating.
    applyStimulus(1'b1, 2, 0, 8'hFE);
    applyStimulus(1'b1, 2, 1, 8'hFF);
    applyStimulus(1'b1, 2, 4, 8'h01);
    waitTick();
    applyStimulus(1'b1, 2, 6, 8'h00);
    repeat (8) @(negedge clk);
    readCheck("t2 wrap byte0", 2, 0, 8'h00);
    readCheck("t2 wrap byte1", 2, 1, 8'h00);
    readCheck("t2 wrap exp", 2, 5, 8'h01);
    applyStimulus(1'b1, 2, 5, 8'h01);
    applyStimulus(1'b1, 2, 4, 8'h09);
    readCheck("t2 ctrl readback", 2, 4, 8'h09);
    readCheck("t2 exp cleared", 2, 5, 8'h00);
    waitTick();
    applyStimulus(1'b1, 2, 6, 8'h00);
    repeat (8) @(negedge clk);
    readCheck("t2 sat byte0", 2, 0, 8'hFF);
    readCheck("t2 sat byte1", 2, 1, 8'hFF);
    readCheck("t2 sat exp", 2, 5, 8'h01);

    // Timer 3: snapshot read of 0x00FF on the cycle the tick rolls it to 0x0100.
    applyStimulus(1'b1, 3, 0, 8'hFF);
    applyStimulus(1'b1, 3, 1, 8'h00);
    applyStimulus(1'b1, 3, 4, 8'h01);
    waitTick();
    applyStimulus(1'b1, 3, 6, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("tick pending on snapshot read", 64'(tick), 64'(1));
    readCheck("t3 byte0 pre-tick", 3, 0, 8'hFF);
    readCheck("t3 byte1 coherent", 3, 1, 8'h00);
    readCheck("t3 byte0 live", 3, 0, 8'h00);
    readCheck("t3 byte1 new snapshot", 3, 1, 8'h01);
    readCheck("t3 byte2 beyond width", 3, 2, 8'h00);

    // Out-of-range timer and unused registers.
    applyStimulus(1'b1, 5, 4, 8'hFF);
    readCheck("t5 ctrl out of range", 5, 4, 8'h00);
    readCheck("t5 byte0 out of range", 5, 0, 8'h00);
    readCheck("t0 ctrl untouched", 0, 4, 8'h01);
    readCheck("t1 reserved reg", 1, 7, 8'h00);
    readCheck("t1 load reg reads 0", 1, 6, 8'h00);

    // Asynchronous reset in the middle of a clock phase.
    readCheck("t0 ctrl before reset", 0, 4, 8'h01);
    checkOutput("irq before reset", 64'(irq), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset dout", 64'(dout), 64'(0));
    checkOutput("async reset irq", 64'(irq), 64'(0));
    checkOutput("async reset tick", 64'(tick), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("no early tick after release", 64'(tick), 64'(0));
    @(negedge clk);
    checkOutput("first tick after release", 64'(tick), 64'(1));
    readCheck("t0 byte0 at first tick", 0, 0, 8'h00);
    readCheck("t0 byte0 after first tick", 0, 0, 8'h01);
    readCheck("t1 ctrl after reset", 1, 4, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
